// File: rtl/decode_issue_stage.sv
// IF/ID + ID/EX stage: captures fetch words, joins two-word (immediate) instructions, issues to execute.
// Latency: a valid IF/ID instruction reaches ID/EX on the next edge; two-word forms cost one bubble.
// Backpressure: if_ready drops on stallD or flushE; stall holds IF/ID and inserts bubbles, flush drops the fetch word.
module decode_issue_stage (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        if_valid,
    input  logic [15:0] if_instr,
    output logic        if_ready,
    input  logic        stallD,
    input  logic        flushE,
    output logic [6:0]  opcode,
    output logic [2:0]  rsrc1,
    output logic [2:0]  rsrc2,
    output logic        ex_valid,
    output logic        ex_load,
    output logic [2:0]  ex_rdst,
    output logic [6:0]  ex_opcode,
    output logic [2:0]  ex_rsrc1,
    output logic [2:0]  ex_rsrc2,
    output logic [15:0] ex_imm
);

    typedef enum logic {FIRST, IMM} state_t;

    typedef struct packed {
        logic        valid;
        logic        load;
        logic [2:0]  rdst;
        logic [6:0]  opcode;
        logic [2:0]  rsrc1;
        logic [2:0]  rsrc2;
        logic [15:0] imm;
    } ex_t;

    state_t      state;
    logic        id_valid;
    logic [15:0] id_instr;
    logic [15:0] hold;
    logic [15:0] sel;
    ex_t         ex;

    function automatic logic two_word(input logic [6:0] op);
        return (op == 7'b0101000) || (op == 7'b1100000) ||
               (op == 7'b1010000) || (op == 7'b1011000);
    endfunction

    function automatic ex_t issue(input logic [15:0] word, input logic [15:0] imm);
        ex_t e;
        e.valid  = 1'b1;
        e.load   = (word[15:9] == 7'b1010000) || (word[15:9] == 7'b1001000);
        e.rdst   = word[8:6];
        e.opcode = word[15:9];
        e.rsrc1  = word[5:3];
        e.rsrc2  = word[2:0];
        e.imm    = imm;
        return e;
    endfunction

    assign if_ready = !stallD && !flushE;

    // While waiting for the immediate, the hazard unit must keep seeing the first word.
    always_comb begin
        sel = '0;
        if (state == IMM)
            sel = hold;
        else if (id_valid)
            sel = id_instr;
    end

    assign opcode = sel[15:9];
    assign rsrc1  = sel[5:3];
    assign rsrc2  = sel[2:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= FIRST;
            id_valid <= 1'b0;
            id_instr <= '0;
            hold     <= '0;
            ex       <= '0;
        end else if (flushE) begin
            id_valid <= 1'b0;
            state    <= FIRST;
            ex       <= '0;
        end else if (stallD) begin
            ex <= '0;
        end else begin
            id_valid <= if_valid;
            id_instr <= if_instr;
            ex       <= '0;
            if (id_valid) begin
                if (state == IMM) begin
                    ex    <= issue(hold, id_instr);
                    state <= FIRST;
                end else if (two_word(id_instr[15:9])) begin
                    hold  <= id_instr;
                    state <= IMM;
                end else begin
                    ex <= issue(id_instr, 16'h0000);
                end
            end
        end
    end

    assign ex_valid  = ex.valid;
    assign ex_load   = ex.load;
    assign ex_rdst   = ex.rdst;
    assign ex_opcode = ex.opcode;
    assign ex_rsrc1  = ex.rsrc1;
    assign ex_rsrc2  = ex.rsrc2;
    assign ex_imm    = ex.imm;

endmodule

// File: tb/tb_decode_issue_stage.sv
// Scoreboard bench for decode_issue_stage: directed hazard scenarios followed by random fetch/stall/flush traffic.
module tb_decode_issue_stage;

    logic        clk;
    logic        rst_n;
    logic        if_valid;
    logic [15:0] if_instr;
    logic        if_ready;
    logic        stallD;
    logic        flushE;
    logic [6:0]  opcode;
    logic [2:0]  rsrc1;
    logic [2:0]  rsrc2;
    logic        ex_valid;
    logic        ex_load;
    logic [2:0]  ex_rdst;
    logic [6:0]  ex_opcode;
    logic [2:0]  ex_rsrc1;
    logic [2:0]  ex_rsrc2;
    logic [15:0] ex_imm;

    decode_issue_stage dut (
        .clk(clk), .rst_n(rst_n),
        .if_valid(if_valid), .if_instr(if_instr), .if_ready(if_ready),
        .stallD(stallD), .flushE(flushE),
        .opcode(opcode), .rsrc1(rsrc1), .rsrc2(rsrc2),
        .ex_valid(ex_valid), .ex_load(ex_load), .ex_rdst(ex_rdst),
        .ex_opcode(ex_opcode), .ex_rsrc1(ex_rsrc1), .ex_rsrc2(ex_rsrc2),
        .ex_imm(ex_imm)
    );

    typedef struct packed {
        logic [33:0] ex;
        logic [12:0] hz;
    } exp_t;

    exp_t exp_q[$];
    int   vectors = 0;
    int   errors  = 0;

    // Reference: the fetched word sitting in IF/ID, plus an optional pending first half.
    logic        m_idv;
    logic [15:0] m_idw;
    logic        m_pending;
    logic [15:0] m_first;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached, vectors=%0d required completion", vectors);
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        vectors++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, req, $time);
        end
    endtask

    function automatic logic [33:0] issued(input logic [15:0] w, input logic [15:0] imm);
        logic [6:0] op;
        logic       ld;
        op = w[15:9];
        ld = (op == 7'd80) || (op == 7'd72);  // LDD = 0x50, POP = 0x48
        return {1'b1, ld, w[8:6], op, w[5:3], w[2:0], imm};
    endfunction

    function automatic logic needs_imm(input logic [6:0] op);
        return op == 7'd40 || op == 7'd96 || op == 7'd80 || op == 7'd88;
    endfunction

    function automatic logic [12:0] hazard_view();
        logic [15:0] w;
        w = 16'h0000;
        if (m_pending)  w = m_first;
        else if (m_idv) w = m_idw;
        return {w[15:9], w[5:3], w[2:0]};
    endfunction

    // Called at a falling edge: drives one cycle of stimulus and predicts the following rising edge.
    task automatic cycle(input logic v, input logic [15:0] w, input logic st, input logic fl);
        exp_t e;
        logic        cv;
        logic [15:0] cw;
        if_valid = v; if_instr = w; stallD = st; flushE = fl;
        e.ex = '0;
        if (fl) begin
            m_idv = 1'b0;
            m_pending = 1'b0;
        end else if (!st) begin
            cv = m_idv; cw = m_idw;
            m_idv = v; m_idw = w;
            if (cv) begin
                if (m_pending) begin
                    e.ex = issued(m_first, cw);
                    m_pending = 1'b0;
                end else if (needs_imm(cw[15:9])) begin
                    m_pending = 1'b1;
                    m_first = cw;
                end else begin
                    e.ex = issued(cw, 16'h0000);
                end
            end
        end
        e.hz = hazard_view();
        exp_q.push_back(e);
        #1;
        check("if_ready", {63'd0, if_ready}, {63'd0, !(st || fl)});
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic do_reset();
        if_valid = 1'b0; if_instr = '0; stallD = 1'b0; flushE = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        check("reset_ex", {30'd0, ex_valid, ex_load, ex_rdst, ex_opcode, ex_rsrc1, ex_rsrc2, ex_imm}, 64'd0);
        check("reset_hazard", {51'd0, opcode, rsrc1, rsrc2}, 64'd0);
        @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        m_idv = 1'b0; m_idw = '0; m_pending = 1'b0; m_first = '0;
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("ex_fields", {30'd0, ex_valid, ex_load, ex_rdst, ex_opcode, ex_rsrc1, ex_rsrc2, ex_imm},
                      {30'd0, e.ex});
                check("hazard_fields", {51'd0, opcode, rsrc1, rsrc2}, {51'd0, e.hz});
            end
        end
    end

    logic [6:0] ops[10] = '{7'd40, 7'd96, 7'd80, 7'd88, 7'd72, 7'd32, 7'd33, 7'd0, 7'd127, 7'd64};

    initial begin
        logic [15:0] w;
        rst_n = 1'b0; if_valid = 1'b0; if_instr = '0; stallD = 1'b0; flushE = 1'b0;
        m_idv = 1'b0; m_idw = '0; m_pending = 1'b0; m_first = '0;
        #3;
        check("por_ex", {30'd0, ex_valid, ex_load, ex_rdst, ex_opcode, ex_rsrc1, ex_rsrc2, ex_imm}, 64'd0);
        check("por_if_ready", {63'd0, if_ready}, 64'd1);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;

        // straight-line ADD r1,r2,r3 then AND
        cycle(1'b1, 16'h4053, 1'b0, 1'b0);
        cycle(1'b1, 16'h4291, 1'b0, 1'b0);
        // IADD with immediate 0x1234
        cycle(1'b1, 16'h5088, 1'b0, 1'b0);
        cycle(1'b1, 16'h1234, 1'b0, 1'b0);
        // POP r2, ADD r3,r2,r1 with a one-cycle load-use stall
        cycle(1'b1, 16'h9080, 1'b0, 1'b0);
        cycle(1'b1, 16'h40D1, 1'b0, 1'b0);
        cycle(1'b1, 16'h4053, 1'b1, 1'b0);
        cycle(1'b1, 16'h4053, 1'b0, 1'b0);
        // stall and flush together while waiting for an immediate
        cycle(1'b1, 16'h5088, 1'b0, 1'b0);
        cycle(1'b1, 16'h1111, 1'b0, 1'b0);
        cycle(1'b1, 16'h2222, 1'b1, 1'b1);
        cycle(1'b1, 16'h4053, 1'b0, 1'b0);
        cycle(1'b0, 16'h0000, 1'b0, 1'b0);
        cycle(1'b0, 16'h0000, 1'b0, 1'b0);
        // async reset while holding an LDM first word
        cycle(1'b1, 16'hC140, 1'b0, 1'b0);
        cycle(1'b1, 16'h00FF, 1'b0, 1'b0);
        do_reset();
        cycle(1'b1, 16'h00FF, 1'b0, 1'b0);
        cycle(1'b1, 16'h4053, 1'b0, 1'b0);
        cycle(1'b0, 16'h0000, 1'b0, 1'b0);

        for (int i = 0; i < 400; i++) begin
            w = 16'($urandom);
            if ($urandom_range(0, 2) != 0) w[15:9] = ops[$urandom_range(0, 9)];
            cycle($urandom_range(0, 3) != 0, w, $urandom_range(0, 4) == 0, $urandom_range(0, 11) == 0);
            if (i == 200) do_reset();
        end

        cycle(1'b0, 16'h0000, 1'b0, 1'b0);
        check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
